// File: rtl/riscv_defines.sv
// Shared core definitions: string-operator encodings and
// the state type of the in-place string sequencer.
package riscv_defines;

   localparam int STR_OP_WIDTH = 3;

   localparam logic [STR_OP_WIDTH-1:0] STR_OP_UPPER = 3'd0;
   localparam logic [STR_OP_WIDTH-1:0] STR_OP_LOWER = 3'd1;
   localparam logic [STR_OP_WIDTH-1:0] STR_OP_LEET  = 3'd2;
   localparam logic [STR_OP_WIDTH-1:0] STR_OP_ROT13 = 3'd3;

   typedef enum logic [2:0] {
      SS_IDLE,
      SS_RD_REQ,
      SS_RD_WAIT,
      SS_WR_REQ,
      SS_WR_WAIT,
      SS_DONE
   } str_seq_state_e;

   function automatic logic str_op_legal(
      input logic [STR_OP_WIDTH-1:0] op
   );
      return (op == STR_OP_UPPER) || (op == STR_OP_LOWER) ||
             (op == STR_OP_LEET)  || (op == STR_OP_ROT13);
   endfunction

endpackage

// File: rtl/riscv_str_lane.sv
// One byte lane of the string sequencer: applies the selected
// character transform and flags a NUL terminator.
module riscv_str_lane
   import riscv_defines::*;
(
   input  logic [STR_OP_WIDTH-1:0] op_i,
   input  logic [7:0]              byte_i,
   output logic [7:0]              byte_o,
   output logic                    is_nul_o
);

   logic       is_lo;
   logic       is_up;
   logic [7:0] fold;

   assign is_lo    = (byte_i >= 8'h61) && (byte_i <= 8'h7A);
   assign is_up    = (byte_i >= 8'h41) && (byte_i <= 8'h5A);
   assign fold     = byte_i | 8'h20;
   assign is_nul_o = (byte_i == 8'h00);

   // Per-operator character mapping; non-letters pass through
   always_comb begin
      byte_o = byte_i;
      case (op_i)
         STR_OP_UPPER: if (is_lo) byte_o = byte_i - 8'd32;
         STR_OP_LOWER: if (is_up) byte_o = byte_i + 8'd32;
         STR_OP_ROT13: begin
            if (is_lo)
               byte_o = (byte_i < 8'h6E) ? byte_i + 8'd13
                                         : byte_i - 8'd13;
            else if (is_up)
               byte_o = (byte_i < 8'h4E) ? byte_i + 8'd13
                                         : byte_i - 8'd13;
         end
         STR_OP_LEET: begin
            if (is_lo || is_up) begin
               case (fold)
                  8'h61:   byte_o = 8'h34;
                  8'h65:   byte_o = 8'h33;
                  8'h69:   byte_o = 8'h31;
                  8'h6F:   byte_o = 8'h30;
                  8'h73:   byte_o = 8'h35;
                  8'h74:   byte_o = 8'h37;
                  default: byte_o = byte_i;
               endcase
            end
         end
         default: byte_o = byte_i;
      endcase
   end

endmodule

// File: rtl/riscv_str_seq.sv
// In-place string transform sequencer: word-wise read, four-lane
// transform, masked write-back, stopping at NUL or length limit.
module riscv_str_seq
   import riscv_defines::*;
#(
   parameter int LEN_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [STR_OP_WIDTH-1:0] operator_i,
   input  logic [31:0]             addr_i,
   input  logic [LEN_WIDTH-1:0]    len_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic [LEN_WIDTH-1:0]    count_o,
   output logic                    data_req_o,
   output logic                    data_we_o,
   output logic [31:0]             data_addr_o,
   output logic [3:0]              data_be_o,
   output logic [31:0]             data_wdata_o,
   input  logic                    data_gnt_i,
   input  logic                    data_rvalid_i,
   input  logic [31:0]             data_rdata_i
);

   str_seq_state_e          state_q, state_d;
   logic [STR_OP_WIDTH-1:0] op_q, op_d;
   logic [31:0]             addr_q, addr_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;
   logic [LEN_WIDTH-1:0]    count_q, count_d;
   logic                    err_q, err_d;
   logic [3:0]              be_q, be_d;
   logic [31:0]             wdata_q, wdata_d;
   logic [2:0]              nact_q, nact_d;
   logic                    stop_q, stop_d;

   logic [31:0]             lane_w;
   logic [3:0]              nul;
   logic [3:0]              act;
   logic [2:0]              nact;
   logic [LEN_WIDTH-1:0]    rem;
   logic [LEN_WIDTH-1:0]    cnt_nx;
   logic                    stop;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      riscv_str_lane u_lane (
         .op_i     (op_q),
         .byte_i   (data_rdata_i[8*g +: 8]),
         .byte_o   (lane_w[8*g +: 8]),
         .is_nul_o (nul[g])
      );
   end

   // Active bytes: before the first NUL and within the remaining length
   always_comb begin
      logic run;
      rem  = len_q - count_q;
      act  = '0;
      nact = '0;
      run  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         run    = run & ~nul[i] & (rem > LEN_WIDTH'(i));
         act[i] = run;
         nact   = nact + {2'b00, run};
      end
      cnt_nx = count_q + LEN_WIDTH'(nact);
      stop   = (|nul) || (cnt_nx == len_q);
   end

   // Next-state and datapath register updates
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      len_d   = len_q;
      count_d = count_q;
      err_d   = err_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      nact_d  = nact_q;
      stop_d  = stop_q;
      case (state_q)
         SS_IDLE: begin
            if (start_i) begin
               op_d    = operator_i;
               addr_d  = {addr_i[31:2], 2'b00};
               len_d   = len_i;
               count_d = '0;
               err_d   = 1'b0;
               if ((addr_i[1:0] != 2'b00) ||
                   !str_op_legal(operator_i)) begin
                  err_d   = 1'b1;
                  state_d = SS_DONE;
               end else if (len_i == '0) begin
                  state_d = SS_DONE;
               end else begin
                  state_d = SS_RD_REQ;
               end
            end
         end
         SS_RD_REQ: begin
            if (data_gnt_i) state_d = SS_RD_WAIT;
         end
         SS_RD_WAIT: begin
            if (data_rvalid_i) begin
               be_d    = act;
               wdata_d = lane_w;
               nact_d  = nact;
               stop_d  = stop;
               state_d = (act == 4'b0000) ? SS_DONE : SS_WR_REQ;
            end
         end
         SS_WR_REQ: begin
            if (data_gnt_i) state_d = SS_WR_WAIT;
         end
         SS_WR_WAIT: begin
            if (data_rvalid_i) begin
               count_d = count_q + LEN_WIDTH'(nact_q);
               if (stop_q) begin
                  state_d = SS_DONE;
               end else begin
                  addr_d  = addr_q + 32'd4;
                  state_d = SS_RD_REQ;
               end
            end
         end
         SS_DONE: state_d = SS_IDLE;
         default: state_d = SS_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SS_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         len_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         nact_q  <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         count_q <= count_d;
         err_q   <= err_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         nact_q  <= nact_d;
         stop_q  <= stop_d;
      end
   end

   // Outputs decoded from state and registers only
   always_comb begin
      busy_o       = (state_q == SS_RD_REQ)  ||
                     (state_q == SS_RD_WAIT) ||
                     (state_q == SS_WR_REQ)  ||
                     (state_q == SS_WR_WAIT);
      done_o       = (state_q == SS_DONE);
      err_o        = done_o & err_q;
      count_o      = count_q;
      data_req_o   = ((state_q == SS_RD_REQ) ||
                      (state_q == SS_WR_REQ)) & ~rst;
      data_we_o    = (state_q == SS_WR_REQ);
      data_addr_o  = addr_q;
      data_wdata_o = wdata_q;
      data_be_o    = 4'h0;
      if (state_q == SS_RD_REQ) data_be_o = 4'hF;
      if (state_q == SS_WR_REQ) data_be_o = be_q;
   end

endmodule

// File: tb/tb_riscv_str_seq.sv
// Scoreboard bench for riscv_str_seq with a stalling memory model.
// Expected writes and completions are queued by stimulus, popped by monitors.
module tb_riscv_str_seq;
   import riscv_defines::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } wr_t;

   typedef struct packed {
      logic        err;
      logic [15:0] cnt;
   } dn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  operator_i;
   logic [31:0] addr_i;
   logic [15:0] len_i;
   logic        busy_o, done_o, err_o;
   logic [15:0] count_o;
   logic        data_req_o, data_we_o;
   logic [31:0] data_addr_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i, data_rvalid_i;
   logic [31:0] data_rdata_i;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:1023];
   wr_t exp_wr[$];
   dn_t exp_dn[$];

   int   stall_n = 0;
   int   scnt = 0;
   int   req_cycles = 0;
   logic pend = 1'b0;
   logic [31:0] pend_data = '0;
   logic [31:0] f_addr;
   logic        f_we;
   logic [3:0]  f_be;
   logic [31:0] f_wd;

   always #5 clk = ~clk;

   riscv_str_seq #(.LEN_WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .operator_i(operator_i), .addr_i(addr_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .count_o(count_o), .data_req_o(data_req_o),
      .data_we_o(data_we_o), .data_addr_o(data_addr_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
      .data_rdata_i(data_rdata_i)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] bemask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

   // Memory slave: stalls grant, answers one cycle after grant,
   // checks request stability and pops expected writes
   always @(negedge clk) begin
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      if (rst) begin
         pend = 1'b0;
         scnt = 0;
      end else begin
         if (pend) begin
            data_rvalid_i = 1'b1;
            data_rdata_i  = pend_data;
            pend = 1'b0;
         end
         if (data_req_o) begin
            req_cycles++;
            if (scnt == 0) begin
               f_addr = data_addr_o;
               f_we   = data_we_o;
               f_be   = data_be_o;
               f_wd   = data_wdata_o;
            end else begin
               chk("stall_addr", data_addr_o, f_addr);
               chk("stall_we", {31'd0, data_we_o}, {31'd0, f_we});
               chk("stall_be", {28'd0, data_be_o}, {28'd0, f_be});
               chk("stall_wdata", data_wdata_o, f_wd);
            end
            if (scnt < stall_n) begin
               scnt++;
            end else begin
               data_gnt_i = 1'b1;
               scnt = 0;
               pend = 1'b1;
               if (data_we_o) begin
                  if (exp_wr.size() == 0) begin
                     chk("unexpected_write", data_addr_o, 32'hFFFFFFFF);
                  end else begin
                     wr_t e;
                     e = exp_wr.pop_front();
                     chk("wr_addr", data_addr_o, e.addr);
                     chk("wr_be", {28'd0, data_be_o}, {28'd0, e.be});
                     chk("wr_data", data_wdata_o & bemask(e.be),
                         e.wdata & bemask(e.be));
                  end
                  mem[data_addr_o[11:2]] =
                     (mem[data_addr_o[11:2]] & ~bemask(data_be_o)) |
                     (data_wdata_o & bemask(data_be_o));
                  pend_data = '0;
               end else begin
                  chk("rd_be", {28'd0, data_be_o}, 32'hF);
                  pend_data = mem[data_addr_o[11:2]];
               end
            end
         end
      end
   end

   // Completion monitor
   always @(negedge clk) begin
      if (!rst && done_o) begin
         if (exp_dn.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            dn_t d;
            d = exp_dn.pop_front();
            chk("done_err", {31'd0, err_o}, {31'd0, d.err});
            chk("done_count", {16'd0, count_o}, {16'd0, d.cnt});
            chk("done_busy", {31'd0, busy_o}, 32'd0);
         end
      end
   end

   task automatic push_wr(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
      wr_t w;
      w.addr = a; w.be = be; w.wdata = wd;
      exp_wr.push_back(w);
   endtask

   task automatic run_cmd(input string nm, input logic [2:0] op,
                          input logic [31:0] a, input logic [15:0] l,
                          input int stall, input logic e,
                          input logic [15:0] c, input int lat,
                          input int nreq);
      dn_t d;
      int  k;
      int  base;
      d.err = e; d.cnt = c;
      exp_dn.push_back(d);
      stall_n = stall;
      @(negedge clk);
      base = req_cycles;
      operator_i = op; addr_i = a; len_i = l; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      if (lat > 1) begin
         chk({nm, "_busy_n1"}, {31'd0, busy_o}, 32'd1);
         chk({nm, "_req_n1"}, {31'd0, data_req_o}, 32'd1);
      end
      k = 1;
      while (!done_o && k < 3000) begin
         @(negedge clk);
         k++;
      end
      if (!done_o) chk({nm, "_timeout"}, 32'd0, 32'd1);
      else if (lat > 0) chk({nm, "_latency"}, k, lat);
      if (nreq >= 0) chk({nm, "_req_cycles"}, req_cycles - base, nreq);
      @(negedge clk);
   endtask

   initial begin
      int k;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      rst = 1'b1; start_i = 1'b0; operator_i = '0;
      addr_i = '0; len_i = '0;
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_done", {31'd0, done_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_count", {16'd0, count_o}, 32'd0);
      chk("rst_req", {31'd0, data_req_o}, 32'd0);
      chk("rst_we", {31'd0, data_we_o}, 32'd0);
      chk("rst_be", {28'd0, data_be_o}, 32'd0);
      chk("rst_addr", data_addr_o, 32'd0);
      chk("rst_wdata", data_wdata_o, 32'd0);
      rst = 1'b0;

      // upper, NUL in second word
      mem[32'h100 >> 2] = 32'h64636261;
      mem[32'h104 >> 2] = 32'h00000065;
      push_wr(32'h100, 4'hF, 32'h44434241);
      push_wr(32'h104, 4'h1, 32'h00000045);
      run_cmd("upper", STR_OP_UPPER, 32'h100, 16'd16, 0,
              1'b0, 16'd5, 9, 4);
      chk("upper_mem0", mem[32'h100 >> 2], 32'h44434241);
      chk("upper_mem1", mem[32'h104 >> 2], 32'h00000045);

      // rot13 cut by length
      mem[32'h200 >> 2] = 32'h6C6C6548;
      mem[32'h204 >> 2] = 32'h2121216F;
      push_wr(32'h200, 4'hF, 32'h79797255);
      push_wr(32'h204, 4'h1, 32'h00000062);
      run_cmd("rot13", STR_OP_ROT13, 32'h200, 16'd5, 0,
              1'b0, 16'd5, 9, 4);
      chk("rot13_mem0", mem[32'h200 >> 2], 32'h79797255);
      chk("rot13_mem1", mem[32'h204 >> 2], 32'h21212162);

      // upper again with three stall cycles on every access
      mem[32'h100 >> 2] = 32'h64636261;
      mem[32'h104 >> 2] = 32'h00000065;
      push_wr(32'h100, 4'hF, 32'h44434241);
      push_wr(32'h104, 4'h1, 32'h00000045);
      run_cmd("stall", STR_OP_UPPER, 32'h100, 16'd16, 3,
              1'b0, 16'd5, 21, 16);
      chk("stall_mem0", mem[32'h100 >> 2], 32'h44434241);
      chk("stall_mem1", mem[32'h104 >> 2], 32'h00000045);

      // error and zero-length commands
      run_cmd("unaligned", STR_OP_UPPER, 32'h102, 16'd4, 0,
              1'b1, 16'd0, 1, 0);
      run_cmd("badop", 3'd5, 32'h100, 16'd4, 0,
              1'b1, 16'd0, 1, 0);
      run_cmd("zerolen", STR_OP_UPPER, 32'h100, 16'd0, 0,
              1'b0, 16'd0, 1, 0);

      // leet, second word starts with NUL
      mem[32'h300 >> 2] = 32'h74736574;
      mem[32'h304 >> 2] = 32'h00000000;
      push_wr(32'h300, 4'hF, 32'h37353337);
      run_cmd("leet", STR_OP_LEET, 32'h300, 16'd16, 0,
              1'b0, 16'd4, 7, 3);
      chk("leet_mem0", mem[32'h300 >> 2], 32'h37353337);
      chk("leet_mem1", mem[32'h304 >> 2], 32'h00000000);

      // lower, length exactly one word: next word never read
      mem[32'h380 >> 2] = 32'h31436241;
      mem[32'h384 >> 2] = 32'h44434241;
      push_wr(32'h380, 4'hF, 32'h31636261);
      run_cmd("lower", STR_OP_LOWER, 32'h380, 16'd4, 0,
              1'b0, 16'd4, 5, 2);
      chk("lower_mem0", mem[32'h380 >> 2], 32'h31636261);
      chk("lower_mem1", mem[32'h384 >> 2], 32'h44434241);

      // reset while the second write is stalled
      mem[32'h400 >> 2] = 32'h64636261;
      mem[32'h404 >> 2] = 32'h68676665;
      push_wr(32'h400, 4'hF, 32'h44434241);
      stall_n = 10;
      @(negedge clk);
      operator_i = STR_OP_UPPER; addr_i = 32'h400;
      len_i = 16'd16; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      k = 0;
      while (!(data_we_o && data_addr_o == 32'h404) && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("rstmid_reached", {31'd0, data_we_o}, 32'd1);
      chk("rstmid_count_before", {16'd0, count_o}, 32'd4);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid_req", {31'd0, data_req_o}, 32'd0);
      chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
      chk("rstmid_count", {16'd0, count_o}, 32'd0);
      rst = 1'b0;
      chk("rstmid_mem0", mem[32'h400 >> 2], 32'h44434241);
      chk("rstmid_mem1", mem[32'h404 >> 2], 32'h68676665);

      mem[32'h500 >> 2] = 32'h64636261;
      push_wr(32'h500, 4'hF, 32'h44434241);
      run_cmd("post_rst", STR_OP_UPPER, 32'h500, 16'd4, 0,
              1'b0, 16'd4, 5, 2);
      chk("post_rst_mem", mem[32'h500 >> 2], 32'h44434241);

      repeat (3) @(negedge clk);
      chk("wr_queue_empty", exp_wr.size(), 32'd0);
      chk("done_queue_empty", exp_dn.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
